gt_tx_framer: RTL and testbench

GT_TX_FRAMER -- requirements
Module: gt_tx_framer

---
 rtl/gt_tx_framer_pkg.sv | 14 +
 rtl/gt_tx_framer.sv | 93 +++++++++
 tb/tb_gt_tx_framer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gt_tx_framer_pkg.sv
// Shared constants and FSM state type for the GT TX framer and its RX checker.
package gt_tx_framer_pkg;

   // Default IDLE word: comma character in the upper byte, data in the lower.
   localparam logic [15:0] c_idle_word = 16'hbc95;
   localparam logic [1:0]  c_idle_k    = 2'b10;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_WAIT_ALIGN,
      ST_RUN
   } framer_state_t;

endpackage

// File: rtl/gt_tx_framer.sv
// GT transmit framer: sends IDLE during link bring-up, then streams payload
// words with a forced IDLE slot every g_IDLE_PERIOD cycles for clock correction.
module gt_tx_framer
   import gt_tx_framer_pkg::*;
#(
   parameter logic [15:0] g_IDLE        = c_idle_word,
   parameter logic [1:0]  g_IDLE_K      = c_idle_k,
   parameter int          g_IDLE_PERIOD = 193,
   parameter int          g_INIT_IDLES  = 64
) (
   input  logic        usrclk_i,
   input  logic        rst_n_i,
   input  logic [15:0] data_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic        rx_aligned_i,
   output logic [15:0] tx_data_o,
   output logic [1:0]  tx_k_o,
   output logic        link_up_o,
   output logic [31:0] tx_word_cnt_o,
   output logic [15:0] drop_cnt_o
);

   localparam logic [15:0] SLOT_LAST = 16'(g_IDLE_PERIOD - 1);
   localparam int          INIT_W    = (g_INIT_IDLES > 2) ? $clog2(g_INIT_IDLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(g_INIT_IDLES - 1);

   framer_state_t     state, state_nxt;
   logic [15:0]       slot_cnt;
   logic [INIT_W-1:0] init_cnt;
   logic              accept;
   logic              align_lost;

   // The last slot of each period refuses a word, so the output cycle that
   // follows (slot 0) is always free for the forced IDLE.
   assign ready_o    = (state == ST_RUN) && (slot_cnt != SLOT_LAST);
   assign link_up_o  = (state == ST_RUN);
   assign accept     = valid_i && ready_o;
   assign align_lost = (state == ST_RUN) && !rx_aligned_i;

   // Next-state logic for the link bring-up FSM.
   always_comb begin
      // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         ST_INIT:       if (init_cnt == INIT_LAST) state_nxt = ST_WAIT_ALIGN;
         ST_WAIT_ALIGN: if (rx_aligned_i)          state_nxt = ST_RUN;
         ST_RUN:        if (!rx_aligned_i)         state_nxt = ST_WAIT_ALIGN;
         default:                                  state_nxt = ST_INIT;
      endcase
   end

   // State register, free-running slot counter and INIT idle counter.
   always_ff @(posedge usrclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: non-blocking assignments keep every register update on the same edge, race-free.
         state    <= ST_INIT;
         slot_cnt <= '0;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 16'd1;
         if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
         else                  init_cnt <= '0;
      end
   end

   // Output word register: an accepted word goes out the next cycle, else IDLE.
   always_ff @(posedge usrclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_data_o     <= g_IDLE;
         tx_k_o        <= g_IDLE_K;
         tx_word_cnt_o <= '0;
      end else if (accept) begin
         tx_data_o     <= data_i;
         tx_k_o        <= 2'b00;
         tx_word_cnt_o <= tx_word_cnt_o + 32'd1;
      end else begin
         tx_data_o     <= g_IDLE;
         tx_k_o        <= g_IDLE_K;
      end
   end

   // Alignment-loss counter, saturating so a flapping link never wraps to zero.
   always_ff @(posedge usrclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         drop_cnt_o <= '0;
      end else if (align_lost && (drop_cnt_o != 16'hffff)) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_gt_tx_framer.sv
// Directed bench for gt_tx_framer: bring-up timing, streaming with forced
// IDLE slots, alignment loss, IDLE-valued payload and mid-stream reset.
module tb_gt_tx_framer;

   localparam int          P       = 193;
   localparam int          N_INIT  = 64;
   localparam logic [15:0] IDLE    = 16'hbc95;
   localparam logic [1:0]  IDLE_K  = 2'b10;

   logic        usrclk_i = 1'b0;
   logic        rst_n_i;
   logic [15:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic        rx_aligned_i;
   logic [15:0] tx_data_o;
   logic [1:0]  tx_k_o;
   logic        link_up_o;
   logic [31:0] tx_word_cnt_o;
   logic [15:0] drop_cnt_o;

   always #5 usrclk_i = ~usrclk_i;

   gt_tx_framer #(
      .g_IDLE        (IDLE),
      .g_IDLE_K      (IDLE_K),
      .g_IDLE_PERIOD (P),
      .g_INIT_IDLES  (N_INIT)
   ) dut (
      .usrclk_i      (usrclk_i),
      .rst_n_i       (rst_n_i),
      .data_i        (data_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .rx_aligned_i  (rx_aligned_i),
      .tx_data_o     (tx_data_o),
      .tx_k_o        (tx_k_o),
      .link_up_o     (link_up_o),
      .tx_word_cnt_o (tx_word_cnt_o),
      .drop_cnt_o    (drop_cnt_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: 0 = INIT, 1 = WAIT_ALIGN, 2 = RUN.
   int          m_state;
   int          m_slot;
   int          m_init;
   logic [31:0] m_cnt;
   logic [15:0] m_drop;
   int          idle_seen;
   logic [15:0] seq;
   logic        acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_slot  = 0;
      m_init  = 0;
      m_cnt   = '0;
      m_drop  = '0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_data"},  32'(tx_data_o),     32'(IDLE));
      check({tag, "_k"},     32'(tx_k_o),        32'(IDLE_K));
      check({tag, "_ready"}, 32'(ready_o),       32'd0);
      check({tag, "_link"},  32'(link_up_o),     32'd0);
      check({tag, "_cnt"},   tx_word_cnt_o,      32'd0);
      check({tag, "_drop"},  32'(drop_cnt_o),    32'd0);
   endtask

   // One clock cycle: called at posedge+1, checks the current cycle, drives
   // inputs, advances the model across the edge and checks the result.
   task automatic cycle(input logic v, input logic [15:0] d, input logic a, output logic accepted);
      logic exp_ready;
      exp_ready = (m_state == 2) && (m_slot != P - 1);
      check("ready", 32'(ready_o),   32'(exp_ready));
      check("link",  32'(link_up_o), 32'(m_state == 2));
      valid_i      = v;
      data_i       = d;
      rx_aligned_i = a;
      accepted     = v && exp_ready;
      case (m_state)
         0: if (m_init == N_INIT - 1) begin m_state = 1; m_init = 0; end
            else m_init++;
         1: if (a) m_state = 2;
         2: if (!a) begin
               m_state = 1;
               if (m_drop != 16'hffff) m_drop++;
            end
         default: m_state = 0;
      endcase
      @(posedge usrclk_i);
      #1;
      m_slot = (m_slot + 1) % P;
      if (accepted) begin
         check("tx_data", 32'(tx_data_o), 32'(d));
         check("tx_k",    32'(tx_k_o),    32'd0);
         m_cnt++;
      end else begin
         check("tx_idle",   32'(tx_data_o), 32'(IDLE));
         check("tx_idle_k", 32'(tx_k_o),    32'(IDLE_K));
         idle_seen++;
      end
      if (m_slot == 0) check("slot0_idle_k", 32'(tx_k_o), 32'(IDLE_K));
      check("word_cnt", tx_word_cnt_o, m_cnt);
      check("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
   endtask

   initial begin
      rst_n_i      = 1'b0;
      valid_i      = 1'b1;
      data_i       = '0;
      rx_aligned_i = 1'b1;
      idle_seen    = 0;
      seq          = '0;
      model_reset();

      #12;
      check_reset_values("por");
      @(negedge usrclk_i);
      rst_n_i = 1'b1;

      // Bring-up: 64 INIT cycles, one WAIT_ALIGN cycle, then RUN.
      for (int i = 1; i <= N_INIT + 1; i++) begin
         cycle(1'b1, 16'(i), 1'b1, acc);
         if (i == N_INIT) check("wait_align_link", 32'(link_up_o), 32'd0);
      end
      check("run_entry_link",  32'(link_up_o),   32'd1);
      check("run_entry_ready", 32'(ready_o),     32'd1);
      check("bringup_cnt",     tx_word_cnt_o,    32'd0);

      // Continuous stream: RUN entered at slot 65, so ready drops at
      // cycles 127 + 193*m -> 10 refusals in 2000 cycles.
      idle_seen = 0;
      for (int i = 0; i < 2000; i++) begin
         cycle(1'b1, seq, 1'b1, acc);
         if (acc) seq++;
      end
      check("stream_words", tx_word_cnt_o,   32'd1990);
      check("stream_idles", 32'(idle_seen),  32'd10);
      check("stream_seq",   32'(seq),        32'd1990);

      // Alignment lost for 5 cycles; the first cycle may still accept a word.
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, seq, 1'b0, acc);
         if (acc) seq++;
      end
      check("drop_once",   32'(drop_cnt_o), 32'd1);
      check("drop_nolink", 32'(link_up_o),  32'd0);
      cycle(1'b1, seq, 1'b1, acc);
      check("realign_link", 32'(link_up_o), 32'd1);

      // Alignment returns in the same cycle it left RUN.
      cycle(1'b1, seq, 1'b0, acc);
      if (acc) seq++;
      check("blip_wait", 32'(link_up_o), 32'd0);
      cycle(1'b1, seq, 1'b1, acc);
      check("blip_run",  32'(link_up_o),  32'd1);
      check("blip_drop", 32'(drop_cnt_o), 32'd2);

      // Pseudo-random valid gaps.
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), seq, 1'b1, acc);
         if (acc) seq++;
      end

      // Payload equal to the IDLE word goes out as data.
      if (m_slot == P - 1) cycle(1'b0, seq, 1'b1, acc);
      cycle(1'b1, 16'hbc95, 1'b1, acc);
      check("idle_payload_acc",  32'(acc),       32'd1);
      check("idle_payload_data", 32'(tx_data_o), 32'h0000bc95);
      check("idle_payload_k",    32'(tx_k_o),    32'd0);

      // Mid-stream reset with a word on the output.
      if (m_slot == P - 1) cycle(1'b0, seq, 1'b1, acc);
      cycle(1'b1, 16'h1234, 1'b1, acc);
      check("pre_reset_data", 32'(tx_data_o), 32'h00001234);
      #3;
      rst_n_i = 1'b0;
      #1;
      check_reset_values("async_rst");
      model_reset();
      @(negedge usrclk_i);
      check_reset_values("held_rst");
      rst_n_i = 1'b1;

      for (int i = 1; i <= N_INIT + 1; i++) begin
         cycle(1'b1, 16'(i), 1'b1, acc);
         if (i == N_INIT) check("re_wait_align_link", 32'(link_up_o), 32'd0);
      end
      check("re_run_entry_link", 32'(link_up_o), 32'd1);
      check("re_run_entry_cnt",  tx_word_cnt_o,  32'd0);
      cycle(1'b1, 16'hcafe, 1'b1, acc);
      check("re_first_word", 32'(tx_data_o), 32'h0000cafe);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
